// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the async SRAM pin responder.
// Lane masks, mode decode, and byte-lane helpers.
package sram_resp_pkg;

    typedef logic [1:0] lane_mask_t;

    localparam logic [7:0] SAT_MAX   = 8'hFF;
    localparam logic [7:0] FILL_BYTE = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } mode_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == SAT_MAX) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] lane_fill(
        input logic [15:0] d,
        input lane_mask_t  m
    );
        return {m[1] ? d[15:8] : FILL_BYTE,
                m[0] ? d[7:0]  : FILL_BYTE};
    endfunction

    function automatic logic [15:0] lane_merge(
        input logic [15:0] old,
        input logic [15:0] nw,
        input lane_mask_t  m
    );
        return {m[1] ? nw[15:8] : old[15:8],
                m[0] ? nw[7:0]  : old[7:0]};
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Async SRAM pin bundle between a controller and the responder.
// master = controller side, slave = responder side.
interface sram_responder_if #(
    parameter int ADDR_WIDTH = 17
);
    logic [ADDR_WIDTH-1:0] sram_a;
    logic [15:0]           sram_dq_in;
    logic                  sram_dq_oe;
    logic                  sram_oe_n;
    logic                  sram_we_n;
    logic                  sram_ub_n;
    logic                  sram_lb_n;
    logic [15:0]           resp_dq;
    logic                  resp_dq_oe;
    logic                  resp_dq_valid;

    modport master (
        output sram_a,
        output sram_dq_in,
        output sram_dq_oe,
        output sram_oe_n,
        output sram_we_n,
        output sram_ub_n,
        output sram_lb_n,
        input  resp_dq,
        input  resp_dq_oe,
        input  resp_dq_valid
    );

    modport slave (
        input  sram_a,
        input  sram_dq_in,
        input  sram_dq_oe,
        input  sram_oe_n,
        input  sram_we_n,
        input  sram_ub_n,
        input  sram_lb_n,
        output resp_dq,
        output resp_dq_oe,
        output resp_dq_valid
    );

endinterface

// File: rtl/sram_resp_checker.sv
// Pin-level protocol checker: short WE pulses, DQ contention and
// address movement during WE low, as saturating 8-bit counters.
module sram_resp_checker
    import sram_resp_pkg::*;
#(
    parameter int ADDR_WIDTH    = 17,
    parameter int MIN_WE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  commit,
    input  logic                  ctrl_dq_oe,
    input  logic                  resp_dq_oe,
    output logic [7:0]            viol_we_short,
    output logic [7:0]            viol_contention,
    output logic [7:0]            viol_addr_in_we
);
    logic [7:0]            we_len;
    logic                  prev_low;
    logic [ADDR_WIDTH-1:0] prev_addr;
    logic                  is_short;

    assign is_short = int'(we_len) < MIN_WE_CYCLES;

    // Track WE low width and the previous address/WE level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_len    <= 8'd0;
            prev_low  <= 1'b0;
            prev_addr <= '0;
        end else begin
            we_len    <= we_n ? 8'd0 : sat_inc(we_len);
            prev_low  <= !we_n;
            prev_addr <= addr;
        end
    end

    // Saturating violation counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            viol_we_short   <= 8'd0;
            viol_contention <= 8'd0;
            viol_addr_in_we <= 8'd0;
        end else begin
            if (commit && is_short)
                viol_we_short <= sat_inc(viol_we_short);
            if (ctrl_dq_oe && resp_dq_oe)
                viol_contention <= sat_inc(viol_contention);
            if (!we_n && prev_low && addr != prev_addr)
                viol_addr_in_we <= sat_inc(viol_addr_in_we);
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Behavioural-equivalent async SRAM device (2^ADDR_WIDTH x 16) on pins.
// Optional checker enabled by defining SRAM_RESP_CHECK_EN.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int ADDR_WIDTH    = 17,
    parameter int ACCESS_CYCLES = 5,
    parameter int MIN_WE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sram_responder_if.slave       pins,
    input  logic                  bd_wr,
    input  logic [ADDR_WIDTH-1:0] bd_addr,
    input  logic [15:0]           bd_data,
    output logic                  bd_ready,
    output logic [7:0]            viol_we_short,
    output logic [7:0]            viol_contention,
    output logic [7:0]            viol_addr_in_we
);
    localparam int CW    = $clog2(ACCESS_CYCLES + 2);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] ACC_LOAD = CW'(ACCESS_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [15:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] addr;
    lane_mask_t            lanes;
    mode_t                 mode;
    logic                  is_read;
    logic                  restart;

    logic                  prev_read;
    logic [ADDR_WIDTH-1:0] prev_addr;
    lane_mask_t            prev_lanes;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_d;
    logic [15:0]           dq_q;
    logic [15:0]           dq_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  oe_q;

    logic [ADDR_WIDTH-1:0] wl_addr;
    logic [15:0]           wl_data;
    lane_mask_t            wl_mask;
    logic                  we_low;
    logic                  commit;
    logic                  bd_take;

    logic [15:0]           rd_word;
    logic [15:0]           ram_q;

    assign addr    = pins.sram_a;
    assign lanes   = {~pins.sram_ub_n, ~pins.sram_lb_n};
    assign is_read = (mode == READ);
    assign restart = is_read && (!prev_read
                  || addr != prev_addr
                  || lanes != prev_lanes);

    assign commit   = pins.sram_we_n && we_low;
    assign bd_ready = !commit;
    assign bd_take  = bd_wr && bd_ready;

    assign pins.resp_dq       = dq_q;
    assign pins.resp_dq_oe    = oe_q;
    assign pins.resp_dq_valid = valid_q;

    // Decode the pin mode; WE low dominates OE.
    always_comb begin
        mode = IDLE;
        unique case (1'b1)
            !pins.sram_we_n:
                mode = WRITE;
            (pins.sram_we_n && !pins.sram_oe_n && |lanes):
                mode = READ;
            default:
                mode = IDLE;
        endcase
    end

    // Access-time counter and read output next state.
    always_comb begin
        cnt_d   = cnt;
        valid_d = 1'b0;
        dq_d    = dq_q;
        if (is_read) begin
            if (restart) begin
                cnt_d = ACC_LOAD;
            end else begin
                if (cnt != '0)
                    cnt_d = cnt - CNT_ONE;
                if (cnt <= CNT_ONE) begin
                    valid_d = 1'b1;
                    dq_d    = lane_fill(ram_q, lanes);
                end
            end
        end
    end

    // Read-side state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_read  <= 1'b0;
            prev_addr  <= '0;
            prev_lanes <= '0;
            cnt        <= '0;
            dq_q       <= 16'h0000;
            valid_q    <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            prev_read  <= is_read;
            prev_addr  <= addr;
            prev_lanes <= lanes;
            cnt        <= cnt_d;
            dq_q       <= dq_d;
            valid_q    <= valid_d;
            oe_q       <= is_read;
        end
    end

    // Latch write pins while WE is low; commit on the rising sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wl_addr <= '0;
            wl_data <= 16'h0000;
            wl_mask <= '0;
            we_low  <= 1'b0;
        end else begin
            if (mode == WRITE) begin
                wl_addr <= addr;
                wl_data <= pins.sram_dq_in;
                wl_mask <= lanes;
            end
            we_low <= (mode == WRITE);
        end
    end

    // Write-first read word for the current address.
    always_comb begin
        rd_word = mem[addr];
        if (commit && wl_addr == addr)
            rd_word = lane_merge(mem[addr], wl_data, wl_mask);
        else if (bd_take && bd_addr == addr)
            rd_word = bd_data;
    end

    // RAM array: pin commit has priority over backdoor.
    always_ff @(posedge clk) begin
        if (commit) begin
            if (wl_mask[1])
                mem[wl_addr][15:8] <= wl_data[15:8];
            if (wl_mask[0])
                mem[wl_addr][7:0] <= wl_data[7:0];
        end else if (bd_wr) begin
            mem[bd_addr] <= bd_data;
        end
        ram_q <= rd_word;
    end

`ifdef SRAM_RESP_CHECK_EN
    sram_resp_checker #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .MIN_WE_CYCLES (MIN_WE_CYCLES)
    ) u_checker (
        .clk             (clk),
        .reset_n         (reset_n),
        .we_n            (pins.sram_we_n),
        .addr            (addr),
        .commit          (commit),
        .ctrl_dq_oe      (pins.sram_dq_oe),
        .resp_dq_oe      (oe_q),
        .viol_we_short   (viol_we_short),
        .viol_contention (viol_contention),
        .viol_addr_in_we (viol_addr_in_we)
    );
`else
    localparam int UNUSED_MIN_WE = MIN_WE_CYCLES;
    logic unused_chk;
    assign unused_chk      = ^{pins.sram_dq_oe, 1'b0};
    assign viol_we_short   = 8'h00;
    assign viol_contention = 8'h00;
    assign viol_addr_in_we = 8'h00;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed scoreboard bench for sram_responder.
// Expected read data comes from a shadow memory model.
module tb_sram_responder;

    localparam int AW = 17;
`ifdef SRAM_RESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          bd_wr;
    logic [AW-1:0] bd_addr;
    logic [15:0]   bd_data;
    logic          bd_ready;
    logic [7:0]    viol_we_short;
    logic [7:0]    viol_contention;
    logic [7:0]    viol_addr_in_we;

    int tests = 0;
    int fails = 0;

    logic [15:0] model [int];
    logic [15:0] exp_q [$];

    sram_responder_if #(.ADDR_WIDTH(AW)) pins ();

    sram_responder #(
        .ADDR_WIDTH    (AW),
        .ACCESS_CYCLES (5),
        .MIN_WE_CYCLES (4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pins            (pins),
        .bd_wr           (bd_wr),
        .bd_addr         (bd_addr),
        .bd_data         (bd_data),
        .bd_ready        (bd_ready),
        .viol_we_short   (viol_we_short),
        .viol_contention (viol_contention),
        .viol_addr_in_we (viol_addr_in_we)
    );

    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] expv
    );
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pins.sram_we_n  = 1'b1;
        pins.sram_oe_n  = 1'b1;
        pins.sram_ub_n  = 1'b1;
        pins.sram_lb_n  = 1'b1;
        pins.sram_dq_oe = 1'b0;
        step();
    endtask

    task automatic bd_load(input logic [AW-1:0] a, input logic [15:0] d);
        bd_wr   = 1'b1;
        bd_addr = a;
        bd_data = d;
        step();
        bd_wr = 1'b0;
        model[int'(a)] = d;
    endtask

    function automatic logic [15:0] fill(
        input logic [15:0] d,
        input logic        ub_n,
        input logic        lb_n
    );
        fill[15:8] = ub_n ? 8'h00 : d[15:8];
        fill[7:0]  = lb_n ? 8'h00 : d[7:0];
    endfunction

    task automatic do_read(
        input logic [AW-1:0] a,
        input logic          ub_n,
        input logic          lb_n,
        input string         tag
    );
        int n;
        logic [15:0] e;
        exp_q.push_back(fill(model[int'(a)], ub_n, lb_n));
        pins.sram_we_n  = 1'b1;
        pins.sram_oe_n  = 1'b0;
        pins.sram_a     = a;
        pins.sram_ub_n  = ub_n;
        pins.sram_lb_n  = lb_n;
        pins.sram_dq_oe = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) begin
                chk({tag, "_oe"}, 32'(pins.resp_dq_oe), 32'd1);
                chk({tag, "_vlo"}, 32'(pins.resp_dq_valid), 32'd0);
            end
        end while (pins.resp_dq_valid !== 1'b1 && n < 12);
        chk({tag, "_lat"}, 32'(n), 32'd6);
        e = exp_q.pop_front();
        chk({tag, "_dq"}, 32'(pins.resp_dq), 32'(e));
    endtask

    task automatic do_write(
        input logic [AW-1:0] a,
        input logic [15:0]   d,
        input logic          ub_n,
        input logic          lb_n,
        input int            n_low,
        input bit            collide,
        input string         tag
    );
        logic [15:0] old;
        pins.sram_we_n  = 1'b0;
        pins.sram_oe_n  = 1'b1;
        pins.sram_a     = a;
        pins.sram_dq_in = d;
        pins.sram_dq_oe = 1'b1;
        pins.sram_ub_n  = ub_n;
        pins.sram_lb_n  = lb_n;
        repeat (n_low) step();
        pins.sram_we_n  = 1'b1;
        pins.sram_dq_oe = 1'b0;
        pins.sram_dq_in = 16'hDEAD;
        pins.sram_a     = a ^ 17'h1;
        pins.sram_ub_n  = 1'b1;
        pins.sram_lb_n  = 1'b1;
        if (collide) begin
            bd_wr   = 1'b1;
            bd_addr = 17'h00060;
            bd_data = 16'h2222;
        end
        #1;
        chk({tag, "_bdrdy"}, 32'(bd_ready), 32'd0);
        step();
        bd_wr = 1'b0;
        old = model.exists(int'(a)) ? model[int'(a)] : 16'h0000;
        model[int'(a)] = {ub_n ? old[15:8] : d[15:8],
                          lb_n ? old[7:0]  : d[7:0]};
        idle();
    endtask

    initial begin
        bd_wr           = 1'b0;
        bd_addr         = '0;
        bd_data         = 16'h0000;
        pins.sram_a     = '0;
        pins.sram_dq_in = 16'h0000;
        pins.sram_dq_oe = 1'b0;
        pins.sram_oe_n  = 1'b1;
        pins.sram_we_n  = 1'b1;
        pins.sram_ub_n  = 1'b1;
        pins.sram_lb_n  = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        chk("rst_dq", 32'(pins.resp_dq), 32'h0);
        chk("rst_oe", 32'(pins.resp_dq_oe), 32'h0);
        chk("rst_valid", 32'(pins.resp_dq_valid), 32'h0);
        chk("rst_bdrdy", 32'(bd_ready), 32'h1);
        chk("rst_short", 32'(viol_we_short), 32'h0);
        chk("rst_cont", 32'(viol_contention), 32'h0);
        chk("rst_addr", 32'(viol_addr_in_we), 32'h0);

        bd_load(17'h00010, 16'hBEEF);
        bd_load(17'h00011, 16'hCAFE);
        bd_load(17'h00020, 16'hFFFF);
        bd_load(17'h00060, 16'h0F0F);
        bd_load(17'h00070, 16'h7777);

        do_read(17'h00010, 1'b0, 1'b0, "rd_beef");
        do_read(17'h00011, 1'b0, 1'b0, "rd_chg_valid");
        idle();

        pins.sram_we_n = 1'b1;
        pins.sram_oe_n = 1'b0;
        pins.sram_a    = 17'h00010;
        pins.sram_ub_n = 1'b0;
        pins.sram_lb_n = 1'b0;
        repeat (4) step();
        chk("rd_mid_cnt2", 32'(pins.resp_dq_valid), 32'd0);
        do_read(17'h00011, 1'b0, 1'b0, "rd_chg_cnt2");

        do_read(17'h00010, 1'b1, 1'b0, "rd_ub_off");
        idle();

        do_write(17'h00020, 16'h1234, 1'b1, 1'b0, 6, 1'b0, "wr_lb");
        do_read(17'h00020, 1'b0, 1'b0, "rd_ff34");
        chk("ff34_const", 32'(pins.resp_dq), 32'h0000FF34);
        idle();
        chk("we_ok_width", 32'(viol_we_short), 32'd0);

        do_write(17'h00030, 16'h5A5A, 1'b0, 1'b0, 2, 1'b0, "wr_short");
        chk("we_short", 32'(viol_we_short), CHK ? 32'd1 : 32'd0);
        do_read(17'h00030, 1'b0, 1'b0, "rd_short");
        idle();

        pins.sram_we_n = 1'b1;
        pins.sram_oe_n = 1'b0;
        pins.sram_a    = 17'h00010;
        pins.sram_ub_n = 1'b0;
        pins.sram_lb_n = 1'b0;
        step();
        pins.sram_dq_oe = 1'b1;
        repeat (3) step();
        pins.sram_dq_oe = 1'b0;
        step();
        chk("contention", 32'(viol_contention), CHK ? 32'd3 : 32'd0);
        idle();

        pins.sram_we_n  = 1'b0;
        pins.sram_oe_n  = 1'b1;
        pins.sram_a     = 17'h00040;
        pins.sram_dq_in = 16'h4141;
        pins.sram_dq_oe = 1'b1;
        pins.sram_ub_n  = 1'b0;
        pins.sram_lb_n  = 1'b0;
        repeat (2) step();
        pins.sram_a = 17'h00041;
        repeat (3) step();
        pins.sram_we_n  = 1'b1;
        pins.sram_dq_oe = 1'b0;
        step();
        model[32'h41] = 16'h4141;
        chk("addr_in_we", 32'(viol_addr_in_we), CHK ? 32'd1 : 32'd0);
        idle();
        do_read(17'h00041, 1'b0, 1'b0, "rd_moved");
        idle();

        do_write(17'h00050, 16'h1111, 1'b0, 1'b0, 4, 1'b1, "wr_coll");
        chk("coll_bdrdy_after", 32'(bd_ready), 32'd1);
        do_read(17'h00050, 1'b0, 1'b0, "rd_coll_pin");
        do_read(17'h00060, 1'b0, 1'b0, "rd_coll_bd");
        idle();

        pins.sram_we_n  = 1'b0;
        pins.sram_oe_n  = 1'b1;
        pins.sram_a     = 17'h00070;
        pins.sram_dq_in = 16'h8888;
        pins.sram_dq_oe = 1'b1;
        pins.sram_ub_n  = 1'b0;
        pins.sram_lb_n  = 1'b0;
        repeat (3) step();
        #2 reset_n = 1'b0;
        #1;
        pins.sram_we_n  = 1'b1;
        pins.sram_dq_oe = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        chk("rst2_short", 32'(viol_we_short), 32'd0);
        chk("rst2_valid", 32'(pins.resp_dq_valid), 32'd0);
        chk("rst2_dq", 32'(pins.resp_dq), 32'd0);
        idle();
        chk("rst2_bdrdy", 32'(bd_ready), 32'd1);
        do_read(17'h00070, 1'b0, 1'b0, "rd_rst_nocommit");
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the external async SRAM pin protocol (128K x 16, UB/LB byte lanes, active-low OE/WE). Samples controller-side pin signals in the controller's clock domain and behaves as the SRAM device, backed by internal RAM. Used in loopback builds and simulation in place of the physical chip, so the SRAM controller and its CPU/video clients can be exercised end-to-end. Optionally checks pin-level timing and bus contention.

## Interface
Parameters:
- ADDR_WIDTH, 17: word address width; depth is 2^ADDR_WIDTH x 16.
- ACCESS_CYCLES, 5: cycles from the start of a read access to valid data.
- MIN_WE_CYCLES, 4: minimum legal WE_n low width, in cycles (checker only).

Ports:
- clk  in  1  single clock, same domain as the controller.
- reset_n  in  1  asynchronous, active-low reset.
- sram_a  in  ADDR_WIDTH  word address.
- sram_dq_in  in  16  data driven by the controller.
- sram_dq_oe  in  1  controller drives DQ.
- sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  in  1 each  active-low controls.
- resp_dq  out  16  read data toward the controller.
- resp_dq_oe  out  1  responder drives DQ.
- resp_dq_valid  out  1  resp_dq has met access time.
- bd_wr  in  1  backdoor preload write strobe.
- bd_addr  in  ADDR_WIDTH, bd_data in 16  backdoor address and data.
- bd_ready  out  1  backdoor write accepted this cycle.
- viol_we_short, viol_contention, viol_addr_in_we  out  8 each  saturating violation counters.

## Operation
- Read mode: we_n=1, oe_n=0, and at least one of ub_n/lb_n low. A cycle in read mode whose sram_a or lane enables differ from the previous cycle, or whose previous cycle was not in read mode, restarts access: wait counter loaded with ACCESS_CYCLES and resp_dq_valid=0.
- Counter decrements each read-mode cycle. At 0: resp_dq = mem[sram_a], with a disabled lane's byte forced to 8'h00, and resp_dq_valid=1. RAM read is registered and issued every cycle on the current address.
- resp_dq_oe=1 in every cycle following a read-mode cycle; 0 otherwise. Outside read mode resp_dq holds its last value.
- Write mode: we_n=0, which dominates oe_n. In each we_n=0 cycle, latch sram_a, sram_dq_in, ~ub_n, ~lb_n. On the first cycle we_n is sampled 1 after low, commit the latched data to RAM under the latched lane mask. A mask of 2'b00 commits nothing.
- The commit uses latched values, because the controller releases the lanes on the same edge as WE_n.
- Backdoor: bd_ready = ~commit. A bd_wr with bd_ready=1 writes all 16 bits. When both occur in the same cycle, the pin commit wins and the backdoor write is dropped; the requester retries.
- Checker counters: we_short increments at commit when the low width was below MIN_WE_CYCLES, and the write still commits. contention increments in each cycle with sram_dq_oe & resp_dq_oe. addr_in_we increments when sram_a changes while we_n=0. All counters saturate at 8'hFF.

## Timing
- Reset: resp_dq=0, resp_dq_oe=0, resp_dq_valid=0, bd_ready=1, counters=0, wait counter=0, latches cleared. RAM contents are not reset.
- Reset asserted mid-write drops the pending commit. Reset asserted mid-read: after release, a new access starts.
- Read latency: data valid ACCESS_CYCLES+1 cycles after the first read-mode cycle at a stable address.
- Write: RAM updated at the clock edge after the WE_n rising sample. A read of that address in the following cycle returns the new data, through the write-first RAM bypass.
- Address change at the same edge as read-mode entry counts as a single restart.

## Configuration
- SRAM_RESP_CHECK_EN defined: the checker is instantiated and the violation counters count.
- Not defined: the checker is removed, all viol_* outputs are tied to 8'h00, and read/write behaviour is identical.

## Structure
- Package sram_resp_pkg holds:
  - Lane-mask typedef (2-bit {ub,lb}).
  - Counter saturation constant 8'hFF.
  - Disabled-lane fill byte 8'h00.
  - Mode enum: IDLE/READ/WRITE.
- Sub-module sram_resp_checker holds the three saturating counters and the WE-width counter, and is instantiated only under SRAM_RESP_CHECK_EN.

## Test plan
- Backdoor preload addr 0x0010=16'hBEEF, then read with oe_n=0, ub/lb=0, held 8 cycles -> resp_dq_valid rises at cycle 6, resp_dq=16'hBEEF, resp_dq_oe=1 from cycle 1.
- Pin write 0x0020=16'h1234 with lb only, WE low 6 cycles, over prior 16'hFFFF -> read returns 16'hFF34.
- Address changes 0x0010→0x0011 mid-read at count 2 -> valid drops at once and returns 6 cycles later with mem[0x0011].
- Read with ub_n=1 on 16'hBEEF -> 16'h00EF.
- WE low 2 cycles -> write committed, viol_we_short=1. sram_dq_oe=1 during a read for 3 cycles -> viol_contention=3 (macro defined); all viol_* =0 when the macro is undefined.
- bd_wr in the same cycle as a pin commit -> bd_ready=0, the backdoor data is not written, and the pin data is stored. Reset mid-WE-low -> no commit.
